// File: rtl/im_read_slave_pkg.sv
// Shared encodings for the instruction-memory AXI read slave: burst and
// response codes, the only supported transfer size, and the FSM states.
package im_read_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // WRAP is treated like INCR over the whole 14-bit word space.
  function automatic logic [13:0] next_word_addr(input logic [13:0] addr,
                                                 input logic [1:0]  burst);
    logic [13:0] nxt;
    nxt = addr;
    if (burst == BURST_INCR || burst == BURST_WRAP) begin
      nxt = addr + 14'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/im_read_slave.sv
// AXI read-only slave in front of a single-cycle instruction SRAM.
// One request at a time; each beat costs one SRAM cycle plus one capture cycle.
module im_read_slave
  import im_read_slave_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] ARID,
  input  logic [31:0]     ARADDR,
  input  logic [3:0]      ARLEN,
  input  logic [2:0]      ARSIZE,
  input  logic [1:0]      ARBURST,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [ID_W-1:0] RID,
  output logic [31:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic            IM_CS,
  output logic            IM_OE,
  output logic [13:0]     IM_A,
  input  logic [31:0]     IM_DO
);

  state_e          state_q, state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            im_cs_q, im_cs_d;
  logic            im_oe_q, im_oe_d;
  logic [13:0]     im_a_q, im_a_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      beat_q, beat_d;
  logic [1:0]      burst_q, burst_d;
  logic            err_q, err_d;
  logic            addr_err;

  // Transfer size and byte lane bits carry no information for a word-only memory.
  logic unused_ok;
  assign unused_ok = ^{ARSIZE, ARADDR[1:0]};

  assign addr_err = |ARADDR[31:16];

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    im_cs_d   = im_cs_q;
    im_oe_d   = im_oe_q;
    im_a_d    = im_a_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          arready_d = 1'b0;
          state_d   = ST_READ;
          rid_d     = ARID;
          len_d     = ARLEN;
          burst_d   = ARBURST;
          err_d     = addr_err;
          rresp_d   = addr_err ? RESP_DECERR : RESP_OKAY;
          beat_d    = 4'd0;
          im_a_d    = ARADDR[15:2];
          // Out-of-range bursts never touch the SRAM.
          im_cs_d   = ~addr_err;
          im_oe_d   = ~addr_err;
        end
      end

      ST_READ: begin
        state_d = ST_DATA;
        im_cs_d = 1'b0;
        im_oe_d = 1'b0;
      end

      ST_DATA: begin
        if (!rvalid_q) begin
          // First DATA cycle: SRAM output is now valid for the address driven in READ.
          rvalid_d = 1'b1;
          rdata_d  = err_q ? 32'h0 : IM_DO;
          rlast_d  = (beat_q == len_q);
        end else if (RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d   = ST_IDLE;
            arready_d = 1'b1;
          end else begin
            state_d = ST_READ;
            beat_d  = beat_q + 4'd1;
            im_a_d  = next_word_addr(im_a_q, burst_q);
            im_cs_d = ~err_q;
            im_oe_d = ~err_q;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        im_cs_d   = 1'b0;
        im_oe_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      im_cs_q   <= 1'b0;
      im_oe_q   <= 1'b0;
      im_a_q    <= 14'h0;
      len_q     <= 4'd0;
      beat_q    <= 4'd0;
      burst_q   <= BURST_FIXED;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      im_cs_q   <= im_cs_d;
      im_oe_q   <= im_oe_d;
      im_a_q    <= im_a_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign IM_CS   = im_cs_q;
  assign IM_OE   = im_oe_q;
  assign IM_A    = im_a_q;

endmodule

// File: tb/tb_im_read_slave.sv
// Bench for im_read_slave: SRAM stub, burst-level reference model checked every
// cycle, directed scenarios with literal expectations, then random bursts.
module tb_im_read_slave;
  import im_read_slave_pkg::*;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ID_W-1:0] ARID = '0;
  logic [31:0]     ARADDR = '0;
  logic [3:0]      ARLEN = '0;
  logic [2:0]      ARSIZE = ARSIZE_WORD;
  logic [1:0]      ARBURST = BURST_INCR;
  logic            ARVALID = 1'b0;
  logic            ARREADY;
  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY = 1'b0;
  logic            IM_CS;
  logic            IM_OE;
  logic [13:0]     IM_A;
  logic [31:0]     IM_DO = '0;

  im_read_slave #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .IM_CS(IM_CS), .IM_OE(IM_OE), .IM_A(IM_A), .IM_DO(IM_DO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {a, 2'b01, ~a[7:0], a[13:6]} ^ 32'hA5C3_0F00;
  endfunction

  // SRAM stub: data only valid the cycle after a selected read; garbage otherwise.
  always @(posedge clk) begin
    IM_DO <= (IM_CS && IM_OE) ? mem_word(IM_A) : $urandom;
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
    logic [13:0] addr;
    logic        cs;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [13:0] ima_log[$];
  int          wait_cnt  = 0;
  bit          m_rv      = 1'b0;
  bit          m_arready = 1'b0;
  logic [13:0] m_ima     = 14'h0;

  // Expand one accepted request into its list of expected beats.
  function automatic void load_burst(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [3:0] len, input logic [1:0] burst);
    beat_t       b;
    logic        err;
    logic [13:0] a;
    err = (addr[31:16] != 16'h0);
    a   = addr[15:2];
    for (int k = 0; k <= int'(len); k++) begin
      b.addr = a;
      b.data = err ? 32'h0 : mem_word(a);
      b.resp = err ? 2'b11 : 2'b00;
      b.id   = id;
      b.last = (k == int'(len));
      b.cs   = !err;
      exp_q.push_back(b);
      if (burst != BURST_FIXED) a = a + 14'd1;
    end
  endfunction

  always @(negedge clk) begin
    beat_t g;
    logic  exp_cs;
    if (rst) begin
      chk("rst_arready", ARREADY, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rlast", RLAST, 0);
      chk("rst_rid", RID, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_rresp", RRESP, 0);
      chk("rst_im_cs", IM_CS, 0);
      chk("rst_im_oe", IM_OE, 0);
      chk("rst_im_a", IM_A, 0);
      exp_q.delete();
      wait_cnt  = 0;
      m_rv      = 1'b0;
      m_arready = 1'b0;
      m_ima     = 14'h0;
    end else begin
      chk("arready", ARREADY, m_arready);
      chk("rvalid", RVALID, m_rv);
      if (m_rv) begin
        chk("rdata", RDATA, exp_q[0].data);
        chk("rresp", RRESP, exp_q[0].resp);
        chk("rid", RID, exp_q[0].id);
        chk("rlast", RLAST, exp_q[0].last);
      end
      exp_cs = (wait_cnt == 2) && exp_q[0].cs;
      chk("im_cs", IM_CS, exp_cs);
      chk("im_oe", IM_OE, exp_cs);
      chk("im_a", IM_A, m_ima);
      if (IM_CS) ima_log.push_back(IM_A);

      // Events that take effect at the coming rising edge.
      if (m_arready && ARVALID) begin
        load_burst(ARID, ARADDR, ARLEN, ARBURST);
        m_ima     = exp_q[0].addr;
        wait_cnt  = 2;
        m_arready = 1'b0;
      end else if (m_rv && RREADY) begin
        g.data = RDATA; g.resp = RRESP; g.id = RID; g.last = RLAST;
        g.addr = exp_q[0].addr; g.cs = exp_q[0].cs;
        got_q.push_back(g);
        void'(exp_q.pop_front());
        m_rv = 1'b0;
        if (exp_q.size() != 0) begin
          wait_cnt = 2;
          m_ima    = exp_q[0].addr;
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) m_rv = 1'b1;
      end
      if (exp_q.size() == 0 && !m_rv && wait_cnt == 0) m_arready = 1'b1;
    end
  end

  // rmode: 0 RREADY always high, 1 random, 2 held low for 3 cycles on beat 0.
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int rmode, input bit spurious,
                          input int rst_beat);
    bit          accepted = 0, done = 0, hs_ar, hs_r, r_last;
    int          beats = 0, stall = 0, cyc = 0;
    logic [31:0] held = '0;
    logic [31:0] rnd;
    got_q.delete();
    ima_log.delete();
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    RREADY = (rmode == 0);
    while (!done && cyc < 400) begin
      @(negedge clk);
      hs_ar  = ARVALID && ARREADY && !accepted;
      hs_r   = RVALID && RREADY;
      r_last = RLAST;
      if (rmode == 2 && RVALID && !RREADY && beats == 0) begin
        if (stall == 1) held = RDATA;
        else if (stall > 1) begin
          chk("stall_rdata", RDATA, held);
          chk("stall_im_cs", IM_CS, 0);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hs_ar) begin
        accepted = 1;
        ARVALID  = spurious;
        if (spurious) begin
          rnd = $urandom; ARADDR = {16'h0, rnd[15:0]}; ARLEN = rnd[19:16]; ARID = rnd[23:20];
        end
      end
      if (hs_r) begin
        beats++;
        if (r_last) begin done = 1; ARVALID = 1'b0; end
      end
      if (!done && rst_beat >= 0 && beats == rst_beat && RVALID) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_async_rvalid", RVALID, 0);
        chk("rst_async_im_a", IM_A, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ARVALID = 1'b0;
        done = 1;
      end
      if (done) RREADY = 1'b0;
      else begin
        case (rmode)
          0: RREADY = 1'b1;
          1: RREADY = ($urandom_range(0, 3) != 0);
          default: begin
            if (RVALID && beats == 0) stall++;
            RREADY = (stall > 3) || (beats > 0);
          end
        endcase
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL burst_timeout actual=%0d cycles required=completion", cyc);
      ARVALID = 1'b0;
      RREADY  = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r, a;
    logic [1:0]  bt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // INCR from 0x10: words 4..7, last flag only on beat 3.
    do_burst(4'd3, 32'h0000_0010, 4'd3, BURST_INCR, 0, 0, -1);
    chk("s1_beats", got_q.size(), 4);
    chk("s1_ima_n", ima_log.size(), 4);
    for (int i = 0; i < 4 && i < ima_log.size(); i++) chk("s1_ima", ima_log[i], 4 + i);
    if (got_q.size() == 4) begin
      chk("s1_last0", got_q[0].last, 0);
      chk("s1_last3", got_q[3].last, 1);
      chk("s1_resp", got_q[2].resp, 0);
      chk("s1_data1", got_q[1].data, mem_word(14'd5));
    end

    // Top of the word space wraps to zero.
    do_burst(4'd1, 32'h0000_FFFC, 4'd1, BURST_INCR, 0, 0, -1);
    chk("s2_beats", got_q.size(), 2);
    chk("s2_ima_n", ima_log.size(), 2);
    if (ima_log.size() == 2) begin
      chk("s2_ima0", ima_log[0], 14'h3FFF);
      chk("s2_ima1", ima_log[1], 14'h0000);
    end

    // FIXED holds the address; spurious ARVALID during the burst is ignored.
    do_burst(4'd2, 32'h0000_0020, 4'd2, BURST_FIXED, 0, 1, -1);
    chk("s3_beats", got_q.size(), 3);
    chk("s3_ima_n", ima_log.size(), 3);
    for (int i = 0; i < ima_log.size(); i++) chk("s3_ima", ima_log[i], 8);

    // Out-of-range address: DECERR, zero data, no SRAM access.
    do_burst(4'd5, 32'h0001_0000, 4'd1, BURST_INCR, 0, 0, -1);
    chk("s4_beats", got_q.size(), 2);
    chk("s4_no_cs", ima_log.size(), 0);
    if (got_q.size() == 2) begin
      chk("s4_data", got_q[0].data, 0);
      chk("s4_resp", got_q[1].resp, 2'b11);
      chk("s4_id", got_q[1].id, 5);
      chk("s4_last", got_q[1].last, 1);
    end

    // Back-pressure on the first beat.
    do_burst(4'd9, 32'h0000_0040, 4'd1, BURST_INCR, 2, 0, -1);
    chk("s5_beats", got_q.size(), 2);
    chk("s5_ima_n", ima_log.size(), 2);

    // Reset mid-burst, then a single-beat burst.
    do_burst(4'd7, 32'h0000_0100, 4'd3, BURST_INCR, 0, 0, 1);
    do_burst(4'd2, 32'h0000_0200, 4'd0, BURST_INCR, 0, 0, -1);
    chk("s6_beats", got_q.size(), 1);
    if (got_q.size() == 1) chk("s6_last", got_q[0].last, 1);
    if (ima_log.size() == 1) chk("s6_ima", ima_log[0], 14'h080);
    else chk("s6_ima_n", ima_log.size(), 1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      a = {16'h0, r[15:2], 2'b00};
      if (r[18:16] == 3'd0) a[31:16] = 16'h0001 + {8'h0, r[31:24]};
      if (r[18:16] == 3'd1) a[15:0] = 16'hFFF0 + {12'h0, r[23:22], 2'b00};
      bt = (r[21:20] == 2'b11) ? BURST_INCR : r[21:20];
      do_burst(r[27:24], a, r[31:28], bt, 1, r[19], -1);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_read_slave.md
IM_READ_SLAVE -- requirements
Module: im_read_slave

Interface
REQ-001 SHALL have the following parameter: ID_W, default 4, width of the AXI ID field.
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ARID  in  ID_W  read request ID.
- ARADDR  in  32  byte address.
- ARLEN  in  4  beats minus one.
- ARSIZE  in  3  fixed 3'b010 (4 bytes).
- ARBURST  in  2  burst type: FIXED, INCR or WRAP.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address accepted.
- RID  out  ID_W  echoed ID.
- RDATA  out  32  instruction word.
- RRESP  out  2  OKAY or DECERR.
- RLAST  out  1  final beat.
- RVALID  out  1  data valid.
- RREADY  in  1  master ready.
- IM_CS  out  1  SRAM chip select.
- IM_OE  out  1  SRAM output enable.
- IM_A  out  14  SRAM word address.
- IM_DO  in  32  SRAM read data, valid one cycle after IM_A while IM_CS and IM_OE are high.

Function
REQ-003 SHALL implement an FSM with three states: IDLE, READ and DATA.
REQ-004 SHALL assert ARREADY only in IDLE; a handshake occurs in any cycle where ARVALID and ARREADY are both high.
REQ-005 On a handshake in IDLE, SHALL latch ARID, ARLEN and ARBURST, load the word address ARADDR[15:2], set the error flag to (ARADDR[31:16] != 0), and go to READ.
REQ-006 In READ, SHALL drive IM_CS=1, IM_OE=1 and IM_A=the current word address, and go to DATA on the next edge.
REQ-007 On entry to DATA, SHALL register RDATA from IM_DO (or 32'h0 if the error flag is set) and assert RVALID.
REQ-008 Latency SHALL be fixed: a handshake at edge T gives RVALID=1 after edge T+2, for every beat.
REQ-009 While RVALID=1 and RREADY=0, RDATA, RID, RRESP and RLAST SHALL remain stable.
REQ-010 RLAST SHALL be 1 only on beat number ARLEN (counting from 0); ARLEN=0 therefore gives a single beat with RLAST=1.
REQ-011 On RVALID&&RREADY when the beat is not the last, SHALL advance the address and go to READ; RVALID is 0 during the READ cycle.
REQ-012 On RVALID&&RREADY on the last beat, SHALL go to IDLE and drop RVALID and RLAST.
REQ-013 Address advance SHALL follow the burst type: INCR and WRAP add 1 to the 14-bit word address, with 14'h3FFF wrapping to 14'h0000; FIXED leaves the address unchanged.
REQ-014 RRESP SHALL be 2'b00 (OKAY) on every beat, or 2'b11 (DECERR) on every beat when the error flag is set.
REQ-015 A DECERR burst SHALL still return exactly ARLEN+1 beats.
REQ-016 RID SHALL equal the latched ARID for the whole burst.
REQ-017 ARVALID asserted outside IDLE SHALL be ignored until the block returns to IDLE (ARREADY=0); there SHALL be no outstanding-request queue.
REQ-018 IM_CS and IM_OE SHALL be 0 outside READ, and IM_A SHALL hold its last value.

Reset
REQ-019 rst=1 SHALL force the following at once, independent of clk: state IDLE, ARREADY=0 while rst is high, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, IM_CS=0, IM_OE=0, IM_A=0, beat counter 0.
REQ-020 Reset asserted mid-burst SHALL abandon the burst; after release, the first handshake SHALL start a fresh burst with no leftover beats.

Structure
REQ-021 A shared package SHALL hold the burst encodings, the response encodings, the ARSIZE_WORD constant and the FSM state enum.
REQ-022 The design SHALL be a single module with no sub-modules; the beat counter and address register are inline.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ARADDR=0x0000_0010, ARLEN=3, INCR, RREADY=1 -> IM_A 4, 5, 6, 7; four beats, each 2 cycles after the previous handshake; RLAST only on beat 3; RRESP=0.
- ARADDR=0x0000_FFFC, ARLEN=1, INCR -> IM_A 0x3FFF then 0x0000; 2 beats.
- ARLEN=2, FIXED, ARADDR=0x20 -> IM_A=8 on all 3 beats.
- ARADDR=0x0001_0000, ARLEN=1, ARID=5 -> 2 beats, RDATA=0, RRESP=2'b11, RID=5, IM_CS stays 0.
- RREADY held low 3 cycles on beat 0 -> RDATA, RLAST and RID stable; no IM_CS pulse until the handshake.
- rst pulsed during beat 1 of an ARLEN=3 burst -> RVALID=0 at once; after release, a new ARLEN=0 request returns exactly one beat.
